// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial LSB-first adder reusing one full-adder cell, IDLE/RUN/DONE control.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic car
);
  assign s   = a ^ b ^ c;
  assign car = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
  logic c_q, c_d, cout_q, cout_d, s, car, last;
  logic [CW-1:0] cnt_q, cnt_d;
  serial_adder_fa u_fa (.a(a_q[0]), .b(b_q[0]), .c(c_q), .s(s), .car(car));
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        a_d     = a;
        b_d     = b;
        c_d     = cin;
        cnt_d   = '0;
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = car;
        r_d   = (r_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
        // counter holds on the final bit so it never wraps inside RUN
        cnt_d = last ? cnt_q : cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          sum_d   = r_d;
          cout_d  = car;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      r_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and randomized checks of serial_adder_ctrl at WIDTH 1, 8 and 32.
module tb_serial_adder_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic s1 = 0, s8 = 0, s32 = 0, c1 = 0, c8 = 0, c32 = 0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic busy1, busy8, busy32, done1, done8, done32, cout1, cout8, cout32;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
  serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_adder_ctrl #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .start(s32), .a(a32), .b(b32), .cin(c32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32));

  task automatic drive(input int w, input logic st, input logic [31:0] av, input logic [31:0] bv, input logic cv);
    case (w)
      1: begin s1 = st; a1 = av[0:0]; b1 = bv[0:0]; c1 = cv; end
      8: begin s8 = st; a8 = av[7:0]; b8 = bv[7:0]; c8 = cv; end
      default: begin s32 = st; a32 = av; b32 = bv; c32 = cv; end
    endcase
  endtask

  task automatic sample(input int w, output logic bz, output logic dz, output logic [32:0] rz);
    case (w)
      1: begin bz = busy1; dz = done1; rz = 33'({cout1, sum1}); end
      8: begin bz = busy8; dz = done8; rz = 33'({cout8, sum8}); end
      default: begin bz = busy32; dz = done32; rz = {cout32, sum32}; end
    endcase
  endtask

  // one full operation; operands change to zero during RUN, which must not matter
  task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic cv,
                       output logic [32:0] res, output int busy_n, output int done_n, output int done_at);
    logic bz, dz;
    logic [32:0] rz;
    busy_n = 0; done_n = 0; done_at = -1; res = 'x;
    @(negedge clk); drive(w, 1'b1, av, bv, cv);
    @(negedge clk); drive(w, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < w + 2; i++) begin
      sample(w, bz, dz, rz);
      if (bz) busy_n++;
      if (dz) begin done_n++; done_at = i; res = rz; end
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string nm, input int w, input logic [31:0] av, input logic [31:0] bv, input logic cv);
    logic [32:0] res;
    int bn, dn, da;
    longint unsigned e;
    e = longint'(av) + longint'(bv) + longint'(cv);
    do_op(w, av, bv, cv, res, bn, dn, da);
    tests += 4;
    if (res !== 33'(e)) begin fails++; $display("FAIL %s w%0d result got %h exp %h", nm, w, res, 33'(e)); end
    if (bn != w) begin fails++; $display("FAIL %s w%0d busy cycles got %0d exp %0d", nm, w, bn, w); end
    if (dn != 1) begin fails++; $display("FAIL %s w%0d done pulses got %0d exp 1", nm, w, dn); end
    if (da != w) begin fails++; $display("FAIL %s w%0d done cycle got %0d exp %0d", nm, w, da, w); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    tests++;
    if ({busy1, done1, sum1, cout1, busy8, done8, sum8, cout8, busy32, done32, sum32, cout32} !== '0) begin
      fails++; $display("FAIL reset outputs not zero b8=%b d8=%b s8=%h c8=%b", busy8, done8, sum8, cout8);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    check_op("zero", 8, 32'h00, 32'h00, 1'b0);
    check_op("carry_ff01", 8, 32'hFF, 32'h01, 1'b0);
    check_op("carry_ffff1", 8, 32'hFF, 32'hFF, 1'b1);
  endtask

  task automatic test_ignore_inputs;
    int dn = 0;
    logic [8:0] res = 'x;
    @(negedge clk); s8 = 1; a8 = 8'h5A; b8 = 8'h3C; c8 = 1;
    @(negedge clk); s8 = 0; a8 = 8'h00; b8 = 8'h00; c8 = 0;
    for (int i = 0; i < 14; i++) begin
      s8 = (i == 2 || i == 5);
      if (done8) begin dn++; res = {cout8, sum8}; end
      @(negedge clk);
    end
    s8 = 0;
    tests += 2;
    if (res !== 9'h097) begin fails++; $display("FAIL ignore_inputs result got %h exp 097", res); end
    if (dn != 1) begin fails++; $display("FAIL ignore_inputs done pulses got %0d exp 1", dn); end
  endtask

  task automatic test_abort;
    int dn = 0;
    logic was_busy;
    @(negedge clk); s8 = 1; a8 = 8'hAA; b8 = 8'h55; c8 = 0;
    @(negedge clk); s8 = 0;
    repeat (3) @(negedge clk);
    was_busy = busy8;
    rst = 1'b1;
    #1;
    tests += 2;
    if (was_busy !== 1'b1) begin fails++; $display("FAIL abort busy before rst got %b exp 1", was_busy); end
    if ({busy8, done8, sum8, cout8} !== 11'h0) begin
      fails++; $display("FAIL abort async clear got b=%b d=%b s=%h c=%b exp all 0", busy8, done8, sum8, cout8);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done8) dn++;
      @(negedge clk);
    end
    tests++;
    if (dn != 0) begin fails++; $display("FAIL abort stray done pulses got %0d exp 0", dn); end
    check_op("after_abort", 8, 32'h01, 32'h01, 1'b0);
  endtask

  task automatic test_back_to_back;
    int t[$];
    @(negedge clk); s8 = 1; a8 = 8'h12; b8 = 8'h34; c8 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done8) begin
        t.push_back(i);
        tests++;
        if ({cout8, sum8} !== 9'h046) begin fails++; $display("FAIL b2b result got %h exp 046", {cout8, sum8}); end
      end
    end
    s8 = 0;
    repeat (12) @(negedge clk);
    tests++;
    if (t.size() != 3) begin fails++; $display("FAIL b2b done count got %0d exp 3", t.size()); end
    else begin
      tests += 2;
      if (t[1] - t[0] != 10) begin fails++; $display("FAIL b2b spacing1 got %0d exp 10", t[1] - t[0]); end
      if (t[2] - t[1] != 10) begin fails++; $display("FAIL b2b spacing2 got %0d exp 10", t[2] - t[1]); end
    end
  endtask

  task automatic test_random(input int w);
    logic [31:0] mask;
    mask = 32'((64'd1 << w) - 1);
    for (int n = 0; n < 1000; n++)
      check_op("rand", w, $urandom & mask, $urandom & mask, 1'($urandom));
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ignore_inputs;
    test_abort;
    test_back_to_back;
    test_random(1);
    test_random(8);
    test_random(32);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
